// File: rtl/mem_fill_ctrl.sv
// mem_fill_ctrl: round-robin line-fill and single-word write controller on one shared memory port
// Ports: CLK, MRST_N (async, active low); per channel req/we/addr/wdata in, gnt/rvalid/done out;
//        shared fill data rdata/word_idx; memory side mem_rd/mem_wr/mem_addr/mem_wdata out, mem_rdata in.
module mem_fill_ctrl #(
  parameter int NCH = 2,
  parameter int LINE_WORDS = 8,
  parameter int LAT = 16,
  parameter bit CWF = 1'b1
) (
  input  logic                          CLK,
  input  logic                          MRST_N,
  input  logic [NCH-1:0]                req,
  input  logic [NCH-1:0]                we,
  input  logic [NCH*32-1:0]             addr,
  input  logic [NCH*32-1:0]             wdata,
  output logic [NCH-1:0]                gnt,
  output logic [NCH-1:0]                rvalid,
  output logic [31:0]                   rdata,
  output logic [$clog2(LINE_WORDS)-1:0] word_idx,
  output logic [NCH-1:0]                done,
  output logic                          mem_rd,
  output logic                          mem_wr,
  output logic [31:0]                   mem_addr,
  output logic [31:0]                   mem_wdata,
  input  logic [31:0]                   mem_rdata
);
  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int CH_W = NCH > 1 ? $clog2(NCH) : 1;
  localparam int CNT_W = $clog2((LAT > LINE_WORDS ? LAT : LINE_WORDS) + 1);
  typedef enum logic [2:0] {IDLE, WR, LATW, BURST, LAST} state_t;
  state_t state, state_n;
  logic [CH_W-1:0] ch, rr, win;
  logic [29:0] aq, win_addr;
  logic [31:0] wd;
  logic [OFF_W-1:0] idx, rv_idx;
  logic [CNT_W-1:0] cnt;
  logic rv, win_we, live;
  // lowest offset from rr with a pending request wins
  always_comb begin
    win = '0;
    for (int i = NCH - 1; i >= 0; i--)
      if (req[(int'(rr) + i) % NCH]) win = CH_W'((int'(rr) + i) % NCH);
    win_addr = addr[int'(win)*32+2 +: 30];
    win_we = we[win];
  end
  always_comb begin
    state_n = state;
    gnt = '0;
    rvalid = '0;
    done = '0;
    mem_rd = 1'b0;
    mem_wr = 1'b0;
    mem_addr = '0;
    mem_wdata = '0;
    live = req[ch];
    case (state)
      IDLE: state_n = ~|req ? IDLE : win_we ? WR : LATW;
      WR: begin
        gnt[ch] = 1'b1;
        mem_wr = 1'b1;
        mem_addr = {aq, 2'b00};
        mem_wdata = wd;
        done[ch] = 1'b1;
        state_n = IDLE;
      end
      LATW: begin
        gnt[ch] = 1'b1;
        state_n = !live ? IDLE : cnt == '0 ? BURST : LATW;
      end
      // rv marks the word read last cycle; a dropped req hides it at once
      BURST: begin
        gnt[ch] = 1'b1;
        mem_rd = 1'b1;
        mem_addr = {aq[29:OFF_W], idx, 2'b00};
        rvalid[ch] = rv & live;
        state_n = !live ? IDLE : cnt == '0 ? LAST : BURST;
      end
      LAST: begin
        gnt[ch] = 1'b1;
        rvalid[ch] = live;
        done[ch] = live;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    rdata = |rvalid ? mem_rdata : '0;
    word_idx = |rvalid ? rv_idx : '0;
  end
  always_ff @(posedge CLK or negedge MRST_N)
    if (!MRST_N) begin
      state <= IDLE;
      ch <= '0;
      rr <= '0;
      aq <= '0;
      wd <= '0;
      idx <= '0;
      rv_idx <= '0;
      cnt <= '0;
      rv <= 1'b0;
    end else begin
      state <= state_n;
      rv <= state == BURST;
      rv_idx <= idx;
      if (state == IDLE && |req) begin
        ch <= win;
        rr <= CH_W'((int'(win) + 1) % NCH);
        aq <= win_addr;
        wd <= wdata[int'(win)*32 +: 32];
        idx <= CWF ? win_addr[OFF_W-1:0] : '0;
        cnt <= CNT_W'(LAT - 1);
      end else if (state == LATW || state == BURST) begin
        cnt <= cnt == '0 ? CNT_W'(LINE_WORDS - 1) : cnt - CNT_W'(1);
        if (state == BURST) idx <= idx + OFF_W'(1);
      end
    end
endmodule
